// File: rtl/md_issue_ctrl_if.sv
// Bundle of the issue-controller request, MDU command/status and writeback signals.
// The slave modport is the controller's view; the master modport is the pipeline/MDU side.
interface md_issue_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic [3:0]        req_op;
    logic [DATA_W-1:0] req_rs;
    logic [DATA_W-1:0] req_rt;
    logic [4:0]        req_dst;
    logic              req_ready;
    logic              mdu_start;
    logic [3:0]        mdu_op;
    logic [DATA_W-1:0] mdu_d1;
    logic [DATA_W-1:0] mdu_d2;
    logic              mdu_busy;
    logic [DATA_W-1:0] mdu_result;
    logic              wb_valid;
    logic [4:0]        wb_dst;
    logic [DATA_W-1:0] wb_data;
    logic              err;

    modport slave (
        input  req_valid, req_op, req_rs, req_rt, req_dst, mdu_busy, mdu_result,
        output req_ready, mdu_start, mdu_op, mdu_d1, mdu_d2, wb_valid, wb_dst, wb_data, err
    );

    modport master (
        output req_valid, req_op, req_rs, req_rt, req_dst, mdu_busy, mdu_result,
        input  req_ready, mdu_start, mdu_op, mdu_d1, mdu_d2, wb_valid, wb_dst, wb_data, err
    );
endinterface

// File: rtl/md_issue_ctrl.sv
// Multiply/divide issue controller: accepts one hi/lo-class instruction at a time,
// drives the MDU command, waits out busy with a watchdog and writes back mfhi/mflo.
module md_issue_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    md_issue_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, READ, WRITE} state_e;

    localparam logic [3:0] OP_NOP = 4'hF;

    state_e            state_q, state_d;
    logic [3:0]        wdog_q, wdog_d;
    logic [4:0]        dst_q, dst_d;
    logic              err_q, err_d;
    logic              mdu_start_q, mdu_start_d;
    logic [3:0]        mdu_op_q, mdu_op_d;
    logic [DATA_W-1:0] mdu_d1_q, mdu_d1_d;
    logic [DATA_W-1:0] mdu_d2_q, mdu_d2_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_dst_q, wb_dst_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command outputs are registered from next-state values so they line up with
    // the state they belong to; rs/rt land directly in the operand registers.
    always_comb begin
        state_d     = state_q;
        wdog_d      = wdog_q;
        dst_d       = dst_q;
        err_d       = 1'b0;
        mdu_start_d = 1'b0;
        mdu_op_d    = OP_NOP;
        mdu_d1_d    = mdu_d1_q;
        mdu_d2_d    = mdu_d2_q;
        wb_valid_d  = 1'b0;
        wb_dst_d    = wb_dst_q;
        wb_data_d   = wb_data_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    dst_d = bus.req_dst;
                    if (bus.req_op[3]) begin
                        err_d = 1'b1;
                    end else if (bus.req_op[2]) begin
                        state_d     = ISSUE;
                        mdu_start_d = 1'b1;
                        mdu_op_d    = bus.req_op;
                        mdu_d1_d    = bus.req_rs;
                        mdu_d2_d    = bus.req_rt;
                    end else if (bus.req_op[1]) begin
                        state_d  = WRITE;
                        mdu_op_d = bus.req_op;
                        mdu_d1_d = bus.req_rs;
                    end else begin
                        state_d  = READ;
                        mdu_op_d = bus.req_op;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                wdog_d  = 4'd0;
            end
            WAIT: begin
                wdog_d = wdog_q + 4'd1;
                if (!bus.mdu_busy) begin
                    state_d = IDLE;
                end else if (wdog_q == 4'd15) begin
                    // Counter holds 0 in the first WAIT cycle, so this is the 16th.
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            READ: begin
                state_d    = IDLE;
                wb_valid_d = 1'b1;
                wb_dst_d   = dst_q;
                wb_data_d  = bus.mdu_result;
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_q      <= 4'd0;
            dst_q       <= 5'd0;
            err_q       <= 1'b0;
            mdu_start_q <= 1'b0;
            mdu_op_q    <= OP_NOP;
            mdu_d1_q    <= '0;
            mdu_d2_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_dst_q    <= 5'd0;
            wb_data_q   <= '0;
        end else begin
            wdog_q      <= wdog_d;
            dst_q       <= dst_d;
            err_q       <= err_d;
            mdu_start_q <= mdu_start_d;
            mdu_op_q    <= mdu_op_d;
            mdu_d1_q    <= mdu_d1_d;
            mdu_d2_q    <= mdu_d2_d;
            wb_valid_q  <= wb_valid_d;
            wb_dst_q    <= wb_dst_d;
            wb_data_q   <= wb_data_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.mdu_start = mdu_start_q;
    assign bus.mdu_op    = mdu_op_q;
    assign bus.mdu_d1    = mdu_d1_q;
    assign bus.mdu_d2    = mdu_d2_q;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_dst    = wb_dst_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with a small behavioural MDU (hi/lo, busy countdown).
module tb_md_issue_ctrl;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    logic stuck;

    md_issue_ctrl_if bus ();

    md_issue_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural MDU: results appear at start, busy lasts 4 (mult) or 9 (div) cycles.
    logic [31:0] hi_m, lo_m;
    int unsigned busy_cnt;

    function automatic logic [63:0] mdu_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        r  = '0;
        case (op)
            4'd4: r = sa * sb;
            4'd5: r = {32'd0, a} * {32'd0, b};
            4'd6: r = (b == 0) ? {a, 32'hFFFFFFFF} : {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
            4'd7: r = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            default: r = '0;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            hi_m     <= '0;
            lo_m     <= '0;
            busy_cnt <= 0;
        end else begin
            if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
            if (bus.mdu_start) begin
                {hi_m, lo_m} <= mdu_calc(bus.mdu_op, bus.mdu_d1, bus.mdu_d2);
                busy_cnt     <= bus.mdu_op[1] ? 9 : 4;
            end
            if (bus.mdu_op == 4'd2) hi_m <= bus.mdu_d1;
            if (bus.mdu_op == 4'd3) lo_m <= bus.mdu_d1;
        end
    end

    assign bus.mdu_busy   = stuck || (busy_cnt != 0);
    assign bus.mdu_result = (bus.mdu_op == 4'd0) ? hi_m : (bus.mdu_op == 4'd1) ? lo_m : 32'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [4:0] dst);
        bus.req_valid = v;
        bus.req_op    = op;
        bus.req_rs    = rs;
        bus.req_rt    = rt;
        bus.req_dst   = dst;
    endtask

    task automatic wait_ready(output int n, output int starts, output int errs);
        n = 0;
        starts = 0;
        errs = 0;
        while (!bus.req_ready && n < 64) begin
            if (bus.mdu_start) starts++;
            if (bus.err) errs++;
            n++;
            step();
        end
    endtask

    initial begin
        int n, starts, errs;
        n_checks = 0;
        n_errors = 0;
        stuck    = 1'b0;
        reset    = 1'b1;
        drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        step();
        step();

        chk("rst_ready",  32'(bus.req_ready), 32'd1);
        chk("rst_start",  32'(bus.mdu_start), 32'd0);
        chk("rst_op",     32'(bus.mdu_op), 32'hF);
        chk("rst_d1",     bus.mdu_d1, 32'd0);
        chk("rst_d2",     bus.mdu_d2, 32'd0);
        chk("rst_wbv",    32'(bus.wb_valid), 32'd0);
        chk("rst_wbdst",  32'(bus.wb_dst), 32'd0);
        chk("rst_wbdata", bus.wb_data, 32'd0);
        chk("rst_err",    32'(bus.err), 32'd0);

        reset = 1'b0;
        step();
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
        step();
        chk("idle_noeffect_op", 32'(bus.mdu_op), 32'hF);

        // mult -2 * 3, then mflo $8 and mfhi $9
        drive(1'b1, 4'd4, 32'hFFFFFFFE, 32'd3, 5'd0);
        step();
        drive(1'b1, 4'd1, 32'd0, 32'd0, 5'd8);
        chk("mul_start", 32'(bus.mdu_start), 32'd1);
        chk("mul_op",    32'(bus.mdu_op), 32'd4);
        chk("mul_d1",    bus.mdu_d1, 32'hFFFFFFFE);
        chk("mul_d2",    bus.mdu_d2, 32'd3);
        wait_ready(n, starts, errs);
        chk("mul_stall",  32'(n), 32'd6);
        chk("mul_starts", 32'(starts), 32'd1);
        step();
        chk("mflo_op", 32'(bus.mdu_op), 32'd1);
        drive(1'b1, 4'd0, 32'd0, 32'd0, 5'd9);
        step();
        chk("mflo_wbv",  32'(bus.wb_valid), 32'd1);
        chk("mflo_dst",  32'(bus.wb_dst), 32'd8);
        chk("mflo_data", bus.wb_data, 32'hFFFFFFFA);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        chk("wbv_pulse", 32'(bus.wb_valid), 32'd0);
        step();
        chk("mfhi_wbv",  32'(bus.wb_valid), 32'd1);
        chk("mfhi_dst",  32'(bus.wb_dst), 32'd9);
        chk("mfhi_data", bus.wb_data, 32'hFFFFFFFF);

        // divu 100/7 with mfhi $2 held valid through the stall
        step();
        drive(1'b1, 4'd7, 32'd100, 32'd7, 5'd0);
        step();
        drive(1'b1, 4'd0, 32'd0, 32'd0, 5'd2);
        wait_ready(n, starts, errs);
        chk("div_stall", 32'(n), 32'd11);
        step();
        chk("div_mfhi_op", 32'(bus.mdu_op), 32'd0);
        drive(1'b1, 4'd1, 32'd0, 32'd0, 5'd4);
        step();
        chk("div_hi_wbv",  32'(bus.wb_valid), 32'd1);
        chk("div_hi_dst",  32'(bus.wb_dst), 32'd2);
        chk("div_hi_data", bus.wb_data, 32'd2);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        step();
        chk("div_lo_dst",  32'(bus.wb_dst), 32'd4);
        chk("div_lo_data", bus.wb_data, 32'd14);

        // mthi then mfhi $3
        drive(1'b1, 4'd2, 32'h12345678, 32'd0, 5'd0);
        step();
        chk("mthi_op",    32'(bus.mdu_op), 32'd2);
        chk("mthi_d1",    bus.mdu_d1, 32'h12345678);
        chk("mthi_start", 32'(bus.mdu_start), 32'd0);
        drive(1'b1, 4'd0, 32'd0, 32'd0, 5'd3);
        step();
        chk("mthi_op_1cyc", 32'(bus.mdu_op), 32'hF);
        chk("mthi_ready",   32'(bus.req_ready), 32'd1);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        step();
        chk("mthi_wbv",  32'(bus.wb_valid), 32'd1);
        chk("mthi_dst",  32'(bus.wb_dst), 32'd3);
        chk("mthi_data", bus.wb_data, 32'h12345678);

        // reset during the 3rd WAIT cycle of a div
        drive(1'b1, 4'd6, 32'hFFFFFF9C, 32'd7, 5'd0);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        step();
        step();
        step();
        chk("midwait_ready", 32'(bus.req_ready), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstwait_ready", 32'(bus.req_ready), 32'd1);
        chk("rstwait_op",    32'(bus.mdu_op), 32'hF);
        chk("rstwait_wbv",   32'(bus.wb_valid), 32'd0);
        chk("rstwait_d1",    bus.mdu_d1, 32'd0);
        step();
        chk("rstwait_ready2", 32'(bus.req_ready), 32'd1);

        // MDU stuck busy after mult: watchdog timeout
        drive(1'b1, 4'd5, 32'd2, 32'd3, 5'd0);
        stuck = 1'b1;
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        wait_ready(n, starts, errs);
        chk("wd_stall",     32'(n), 32'd17);
        chk("wd_err_early", 32'(errs), 32'd0);
        chk("wd_err",       32'(bus.err), 32'd1);
        step();
        chk("wd_err_once",  32'(bus.err), 32'd0);
        chk("wd_idle",      32'(bus.req_ready), 32'd1);
        stuck = 1'b0;

        // invalid op 9
        drive(1'b1, 4'd9, 32'hDEADBEEF, 32'd1, 5'd5);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        chk("inv_err",   32'(bus.err), 32'd1);
        chk("inv_start", 32'(bus.mdu_start), 32'd0);
        chk("inv_op",    32'(bus.mdu_op), 32'hF);
        chk("inv_ready", 32'(bus.req_ready), 32'd1);
        step();
        chk("inv_err_once", 32'(bus.err), 32'd0);
        chk("inv_wbv",      32'(bus.wb_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
